// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its prefetch queue.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int PC_INC     = 4;
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = '0;

    // Queue entry. Fields are FETCH_XLEN wide; narrower DATA_W/ADDR_W values are zero-extended.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding fetched {pc, instr} entries; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = i_push & ~i_flush;
    assign do_pop  = i_pop & (count_q != '0) & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    assign o_head  = mem[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/stage_fetch_q.sv
// Pipelined instruction fetch: IMEM with 1-cycle registered read feeding a credit-checked prefetch queue.
// Optional single-step gating of issue is enabled by defining FETCH_STEP_EN.
module stage_fetch_q
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                IMEM_AW  = 8,
    parameter int                Q_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_step,
    input  logic               i_taken,
    input  logic [ADDR_W-1:0]  i_branch_address,
    input  logic               i_pc_write,
    input  logic               i_imem_we,
    input  logic [IMEM_AW-1:0] i_imem_waddr,
    input  logic [DATA_W-1:0]  i_imem_wdata,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_instruction,
    output logic [ADDR_W-1:0]  o_pc
);

    localparam int CNT_W = $clog2(Q_DEPTH) + 1;

    logic [DATA_W-1:0]  imem_mem [2**IMEM_AW];
    logic [DATA_W-1:0]  rdata_q;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic               inflight_q, inflight_d;
    logic [IMEM_AW-1:0] rd_idx;
    logic               run, pop, issue;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W:0]     credit;
    fetch_entry_t       push_entry, head;

`ifdef FETCH_STEP_EN
    assign run = i_step;
`else
    assign run = 1'b1;
    logic unused_step;
    assign unused_step = i_step;
`endif

    assign pop    = o_valid & i_ready;
    // Slots already claimed once this cycle's pop and pending landing are accounted for.
    assign credit = (CNT_W+1)'(occ) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue  = run & i_pc_write & ~i_taken & (credit < (CNT_W+1)'(Q_DEPTH));
    assign rd_idx = fpc_q[IMEM_AW+1:2];

    always_comb begin
        fpc_d      = fpc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        if (i_taken) begin
            fpc_d = i_branch_address;
        end else if (issue) begin
            fpc_d = fpc_q + ADDR_W'(PC_INC);
            tag_d = fpc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q      <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Read-before-write: a same-cycle write to the read index returns the old word.
    always_ff @(posedge clk) begin
        if (i_imem_we) begin
            imem_mem[i_imem_waddr] <= i_imem_wdata;
        end
        if (issue) begin
            rdata_q <= imem_mem[rd_idx];
        end
    end

    assign push_entry.pc    = FETCH_XLEN'(tag_q);
    assign push_entry.instr = FETCH_XLEN'(rdata_q);

    // A redirect flushes the queue, which also discards the landing read.
    fetch_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (inflight_q),
        .i_pop   (pop),
        .i_flush (i_taken),
        .i_data  (push_entry),
        .o_head  (head),
        .o_count (occ)
    );

    assign o_valid       = (occ != '0);
    assign o_instruction = o_valid ? DATA_W'(head.instr) : DATA_W'(NOP_INSTR);
    assign o_pc          = o_valid ? ADDR_W'(head.pc) + ADDR_W'(PC_INC) : '0;

endmodule

// File: tb/tb_stage_fetch_q.sv
// Self-checking bench for stage_fetch_q: directed scenarios plus randomized traffic against a queue-based reference.
`timescale 1ns/1ps
module tb_stage_fetch_q;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst, step, taken, pc_write, imem_we, ready;
    logic [31:0] br_addr, imem_wdata;
    logic [7:0]  imem_waddr;
    logic        o_valid;
    logic [31:0] o_instruction, o_pc;

    stage_fetch_q #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .IMEM_AW  (8),
        .Q_DEPTH  (QD),
        .RESET_PC (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_step           (step),
        .i_taken          (taken),
        .i_branch_address (br_addr),
        .i_pc_write       (pc_write),
        .i_imem_we        (imem_we),
        .i_imem_waddr     (imem_waddr),
        .i_imem_wdata     (imem_wdata),
        .o_valid          (o_valid),
        .i_ready          (ready),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: architectural view of the stage as a PC counter, one outstanding read and an ordered queue.
    logic [31:0] ref_mem [256];
    logic [31:0] m_fpc;
    logic [31:0] mq_pc  [$];
    logic [31:0] mq_ins [$];
    bit          m_busy;
    logic [31:0] m_busy_pc, m_busy_ins;
    logic [31:0] log_ins [$];

    function automatic void model_step();
        bit pop_now, issue_now, run_now;
        if (rst) begin
            mq_pc.delete();
            mq_ins.delete();
            m_busy = 1'b0;
            m_fpc  = 32'h0;
        end else begin
            pop_now = (mq_pc.size() > 0) && ready;
`ifdef FETCH_STEP_EN
            run_now = step;
`else
            run_now = 1'b1;
`endif
            issue_now = run_now && pc_write && !taken &&
                        (mq_pc.size() + int'(m_busy) - int'(pop_now) < QD);
            if (pop_now) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (m_busy) begin
                mq_pc.push_back(m_busy_pc);
                mq_ins.push_back(m_busy_ins);
            end
            if (taken) begin
                mq_pc.delete();
                mq_ins.delete();
            end
            m_busy = issue_now;
            if (issue_now) begin
                m_busy_pc  = m_fpc;
                m_busy_ins = ref_mem[m_fpc[9:2]];
            end
            if (taken)          m_fpc = br_addr;
            else if (issue_now) m_fpc = m_fpc + 32'd4;
        end
        if (imem_we) ref_mem[imem_waddr] = imem_wdata;
    endfunction

    task automatic cmp_model();
        bit v;
        v = (mq_pc.size() > 0);
        check_eq("valid", 32'(o_valid), 32'(v));
        check_eq("instr", o_instruction, v ? mq_ins[0] : 32'h0);
        check_eq("pc",    o_pc,          v ? mq_pc[0] + 32'd4 : 32'h0);
    endtask

    // One clock: record the transfer (if any), advance DUT and model, compare at the falling edge.
    task automatic tick();
        if (o_valid && ready) begin
            log_ins.push_back(o_instruction);
            if (verbose) $display("xfer pc=0x%08h instr=0x%08h", o_pc, o_instruction);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        rst = 1'b1; step = 1'b1; taken = 1'b0; pc_write = 1'b1; imem_we = 1'b0;
        ready = 1'b0; br_addr = '0; imem_waddr = '0; imem_wdata = '0;

        // Program load under reset.
        for (int i = 0; i < 256; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 8'(i);
            imem_wdata = (i < 4) ? 32'h11 * 32'(i + 1) : 32'hA000_0000 + 32'(i);
            tick();
        end
        imem_we = 1'b0;
        tick();
        check_eq("rst_valid", 32'(o_valid), 32'h0);
        check_eq("rst_instr", o_instruction, 32'h0);
        check_eq("rst_pc",    o_pc,          32'h0);

        // Release with decode ready: first valid two cycles later, then back to back.
        verbose = 1'b1;
        rst = 1'b0; ready = 1'b1;
        tick();
        check_eq("lat_c1_valid", 32'(o_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("seq_valid", 32'(o_valid), 32'h1);
            check_eq("seq_instr", o_instruction, 32'h11 * 32'(k + 1));
            check_eq("seq_pc",    o_pc,          32'(4 * (k + 1)));
        end

        // Reset mid-stream drops everything.
        rst = 1'b1; ready = 1'b0;
        tick();
        check_eq("rstmid_valid", 32'(o_valid), 32'h0);
        rst = 1'b0;

        // Back-pressure: queue saturates, head holds.
        for (int k = 0; k < 10; k++) tick();
        check_eq("hold_instr", o_instruction, 32'h11);
        check_eq("hold_pc",    o_pc,          32'h4);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq("resume_instr", o_instruction, (k < 4) ? 32'h11 * 32'(k + 1) : 32'hA000_0004);
            check_eq("resume_pc",    o_pc,          32'(4 * (k + 1)));
            tick();
        end

        // Redirect while full.
        ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        taken = 1'b1; br_addr = 32'h40;
        tick();
        taken = 1'b0; ready = 1'b1;
        check_eq("redir_n1_valid", 32'(o_valid), 32'h0);
        tick();
        check_eq("redir_n2_valid", 32'(o_valid), 32'h0);
        tick();
        check_eq("redir_n3_valid", 32'(o_valid), 32'h1);
        check_eq("redir_instr",    o_instruction, 32'hA000_0010);
        check_eq("redir_pc",       o_pc,          32'h44);
        for (int k = 0; k < 8; k++) tick();

        // Hazard stall: queue drains, pending read still lands.
        pc_write = 1'b0;
        tick();
        check_eq("stall_drain_valid", 32'(o_valid), 32'h1);
        tick();
        tick();
        check_eq("stall_empty_valid", 32'(o_valid), 32'h0);
        pc_write = 1'b1;
        for (int k = 0; k < 6; k++) tick();

`ifdef FETCH_STEP_EN
        // Single-step: three pulses, exactly three instructions.
        rst = 1'b1;
        tick();
        rst = 1'b0; step = 1'b0; ready = 1'b1;
        log_ins.delete();
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            for (int k = 0; k < 3; k++) tick();
        end
        for (int k = 0; k < 6; k++) tick();
        check_eq("step_count", 32'(log_ins.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq("step_instr", (k < log_ins.size()) ? log_ins[k] : 32'hDEAD_BEEF, 32'h11 * 32'(k + 1));
        end
        check_eq("step_idle_valid", 32'(o_valid), 32'h0);
        step = 1'b1;
`endif

        // Randomized traffic.
        verbose = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            ready      = ($urandom_range(0, 3) != 0);
            pc_write   = ($urandom_range(0, 7) != 0);
            taken      = ($urandom_range(0, 19) == 0);
            br_addr    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step       = ($urandom_range(0, 1) == 1);
            imem_we    = ($urandom_range(0, 9) == 0);
            imem_waddr = 8'($urandom_range(20, 255));
            imem_wdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_fetch_q.md
# stage_fetch_q

Parametrised instruction-fetch stage with an on-chip instruction memory, a decoupling prefetch queue and a valid/ready handshake toward decode. It sits between the branch-resolution logic (MEM stage) and the decode stage. It replaces the single-register fetch path with a pipelined fetch that supports stall, redirect/flush, program loading and optional single-step execution.

## Interface
Parameters:
- `DATA_W`, 32: instruction width.
- `ADDR_W`, 32: PC width.
- `IMEM_AW`, 8: IMEM word-index width (2^IMEM_AW words).
- `Q_DEPTH`, 4: prefetch queue depth, power of two, ≥2.
- `RESET_PC`, 0: PC after reset, word aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_step`  in  1  single-step pulse (see Configuration).
- `i_taken`  in  1  redirect request from branch resolution.
- `i_branch_address`  in  ADDR_W  redirect target.
- `i_pc_write`  in  1  0 = hazard stall; no new fetch issued.
- `i_imem_we`  in  1  IMEM write enable (program load).
- `i_imem_waddr`  in  IMEM_AW  IMEM write word index.
- `i_imem_wdata`  in  DATA_W  IMEM write data.
- `o_valid`  out  1  queue head holds an instruction.
- `i_ready`  in  1  decode accepts the head this cycle.
- `o_instruction`  out  DATA_W  head instruction.
- `o_pc`  out  ADDR_W  head fetch PC + 4, the sequential successor.

## Operation
- Fetch PC register `fpc`. IMEM read index is `fpc[IMEM_AW+1:2]`. The index wraps modulo IMEM size, with no error.
- Issue condition: `issue = run & i_pc_write & ~i_taken & (occ + inflight - pop < Q_DEPTH)`.
  - `pop = o_valid & i_ready`.
  - `run` is 1 unless gated by step mode.
- On issue: IMEM read at `fpc`, `inflight <= 1`, tag `<= fpc`, `fpc <= fpc + 4` (mod 2^ADDR_W).
- Cycle after issue: IMEM data plus tag are pushed into the queue, unless the read was killed.
- `i_taken` (redirect):
  - `fpc <= i_branch_address`.
  - Queue flushed (occupancy 0).
  - In-flight read killed and never pushed.
  - Redirect wins over `i_pc_write = 0` and over issue in the same cycle.
- Pop in a redirect cycle is still a completed transfer. Decode squashes it.
- Simultaneous push and pop: occupancy unchanged. Push into a queue that is full after pop cannot occur, because credits prevent it.
- `i_imem_we` writes IMEM synchronously. A read of the same index in the same cycle returns old data.
- Outputs when `o_valid = 0`: `o_instruction = 0`, `o_pc = 0`.

## Timing
- Reset values: `fpc = RESET_PC`, occupancy 0, `inflight = 0`, `o_valid = 0`, `o_instruction = 0`, `o_pc = 0`. IMEM contents are not reset.
- Reset mid-operation: all in-flight and queued instructions are dropped. The first issue occurs in the first cycle with `rst = 0`.
- Fetch latency: issue in cycle N → `o_valid = 1` with that instruction in cycle N+2.
- Throughput: one instruction per cycle sustained while `i_ready = 1` and `i_pc_write = 1`.
- Redirect in cycle N: target issued in N+1 and presented in N+3. `o_valid = 0` in N+1 and N+2.
- Handshake rules:
  - Head is stable while `o_valid & ~i_ready`.
  - `o_valid` never drops without a pop, redirect or reset.
- Stall (`i_pc_write = 0`) blocks issue only. The queue keeps draining, and an in-flight read still lands.

## Configuration
- `FETCH_STEP_EN` defined:
  - `run = i_step`, so at most one instruction is issued per cycle with `i_step = 1`.
  - A redirect still applies without `i_step`.
- Not defined: `run = 1` and `i_step` is ignored. The port stays present.

## Structure
- Shared package `fetch_pkg`:
  - `PC_INC = 4`
  - `NOP_INSTR = 0`
  - entry struct `{pc, instr}`.
- Sub-module `fetch_queue`: synchronous FIFO with push, pop, flush and occupancy. Flush has priority over push.
- IMEM is inferred in the top level as a 1-cycle-read register array.

## Test plan
- Load IMEM[0..3] = 0x11,0x22,0x33,0x44, then release reset with `i_ready = 1` → `o_valid` in cycle 2. Instructions 0x11..0x44 appear on consecutive cycles with `o_pc` = 4,8,12,16.
- Hold `i_ready = 0` for 10 cycles → occupancy saturates at `Q_DEPTH`, `fpc` stops at 4·Q_DEPTH and the head stays 0x11. On release, the stream continues with no gap or duplicate.
- `i_taken = 1` with `i_branch_address = 0x40` while the queue is full → next valid instruction is IMEM[16] with `o_pc = 0x44`, arriving 3 cycles later. No stale entries appear.
- `i_pc_write = 0` for 3 cycles with `i_ready = 1` → queue drains and `o_valid` falls. The resumed stream has no skipped PC.
- Assert `rst` mid-stream → next cycle `o_valid = 0`. The stream restarts at `RESET_PC`.
- With `FETCH_STEP_EN` defined, apply 3 single-cycle `i_step` pulses → exactly 3 instructions are delivered (0x11, 0x22, 0x33), then `o_valid` stays 0.
